// File: rtl/mac_vector_engine.sv
// mac_vector_engine: OUT_CH signed dot products of a stored input vector against per-channel
// weight rows, with optional ReLU, output saturation and an atomic packed result update.
module mac_vector_engine #(
    parameter int IN_LEN = 16,
    parameter int IN_W   = 8,
    parameter int W_W    = 8,
    parameter int OUT_CH = 10,
    parameter int OUT_W  = 16,
    parameter int ACC_W  = 32,
    localparam int IAW   = $clog2(IN_LEN),
    localparam int WAW   = $clog2(OUT_CH*IN_LEN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_we,
    input  logic [IAW-1:0]          in_addr,
    input  logic [IN_W-1:0]         in_data,
    input  logic                    w_we,
    input  logic [WAW-1:0]          w_addr,
    input  logic [W_W-1:0]          w_data,
    input  logic                    start,
    input  logic                    relu_en,
    output logic                    busy,
    output logic                    done,
    output logic [OUT_CH*OUT_W-1:0] q
);
    localparam int CW = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, ACCUM, STORE, DONE} state_t;

    state_t                  state_q;
    logic [IN_W-1:0]         x_mem [IN_LEN];
    logic [W_W-1:0]          w_mem [OUT_CH*IN_LEN];
    logic [IAW-1:0]          idx_q;
    logic [CW-1:0]           ch_q;
    logic signed [ACC_W-1:0] acc_q, acc_d, prod, v;
    logic [IN_W-1:0]         x_rd;
    logic [W_W-1:0]          w_rd;
    logic [WAW-1:0]          w_rd_addr;
    logic [OUT_W-1:0]        sat;
    logic                    relu_q, busy_q, done_q;
    logic [OUT_CH*OUT_W-1:0] shadow_q, q_q;

    // Memories keep their contents across reset; writes are locked out while computing.
    always_ff @(posedge clk) begin
        if (in_we && !busy_q && int'(in_addr) < IN_LEN)
            x_mem[in_addr] <= in_data;
        if (w_we && !busy_q && int'(w_addr) < OUT_CH*IN_LEN)
            w_mem[w_addr] <= w_data;
    end

    assign w_rd_addr = WAW'(ch_q) * WAW'(IN_LEN) + WAW'(idx_q);
    assign x_rd      = x_mem[idx_q];
    assign w_rd      = w_mem[w_rd_addr];
    assign prod      = $signed({{(ACC_W-IN_W){x_rd[IN_W-1]}}, x_rd}) *
                       $signed({{(ACC_W-W_W){w_rd[W_W-1]}}, w_rd});
    assign acc_d     = acc_q + prod;

    always_comb begin
        v   = (relu_q && acc_q < 0) ? '0 : acc_q;
        sat = (v > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : (v < SAT_MIN) ? SAT_MIN[OUT_W-1:0] : v[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            ch_q     <= '0;
            acc_q    <= '0;
            relu_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            shadow_q <= '0;
            q_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    relu_q  <= relu_en;
                    ch_q    <= '0;
                    idx_q   <= '0;
                    acc_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= ACCUM;
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + IAW'(1);
                    if (idx_q == IAW'(IN_LEN-1))
                        state_q <= STORE;
                end
                STORE: begin
                    shadow_q[ch_q*OUT_W +: OUT_W] <= sat;
                    idx_q <= '0;
                    acc_q <= '0;
                    if (ch_q == CW'(OUT_CH-1)) begin
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        ch_q    <= ch_q + CW'(1);
                        state_q <= ACCUM;
                    end
                end
                DONE: begin
                    q_q     <= shadow_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;
endmodule
